ras_ctrl: RTL and testbench
===========================

# ras_ctrl

Control-side driver of the return-address-stack interface. Decodes each instruction accepted by fetch, classifies it as call, return, coroutine swap or plain control flow, and drives the RAS push, pop, new-address and branch-checkpoint strobes one cycle later. It also counts outstanding speculative checkpoints so that fetch stalls before the RAS index checkpoint FIFO (depth MAX_IDS) can overflow. It sits between the fetch stage and the ras block.

## Interface
- MAX_IDS, 8: maximum outstanding speculative checkpoints; must equal the RAS checkpoint FIFO depth.
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- fetch_valid  in  1  instruction accepted by fetch this cycle
- fetch_pc  in  32  PC of the accepted instruction
- fetch_instr  in  32  raw instruction word
- fetch_flush  in  1  global fetch flush (mispredict/exception)
- early_flush  in  1  early-branch flush that also resets RAS checkpoints
- branch_retired_in  in  1  a checkpointed control-flow instruction retired
- ras_push  out  1  push ras_new_addr
- ras_pop  out  1  pop top of stack
- ras_new_addr  out  32  return address (pc+4)
- ras_branch_fetched  out  1  save RAS index checkpoint
- ras_branch_retired  out  1  release oldest checkpoint
- ckpt_full  out  1  fetch must not accept control-flow instructions
- ckpt_overflow  out  1  sticky error: control flow accepted while full

## Operation
- link(r) is true for r == x1 or r == x5.
- Control flow: BRANCH (1100011), JAL (1101111), JALR (1100111, funct3 = 000). Any other word produces no strobes.
- JAL: push if link(rd).
- JALR cases:
  - !link(rd) & link(rs1): pop.
  - link(rd) & !link(rs1): push.
  - link(rd) & link(rs1) & rd == rs1: push.
  - link(rd) & link(rs1) & rd != rs1: pop+push (see Configuration).
- Every BRANCH, JAL and JALR asserts ras_branch_fetched.
- ras_new_addr = fetch_pc + 4 (32-bit, wraps modulo 2^32); it is 0 when ras_push is low.
- Checkpoint counter cnt, width $clog2(MAX_IDS+1):
  - +1 on ras_branch_fetched, −1 on ras_branch_retired; both in the same cycle leave it unchanged.
  - Cleared to 0 on fetch_flush or early_flush; the clear takes priority over any increment or decrement.
- ras_branch_retired = branch_retired_in & (cnt != 0). A retire arriving with an empty counter is dropped and does not underflow.
- ckpt_full = (cnt + pending) >= MAX_IDS, where pending is the registered-stage ras_branch_fetched.
- If a control-flow instruction is accepted while ckpt_full is high:
  - No strobes are issued for it.
  - ckpt_overflow sets and stays set until reset.
  - cnt does not change.

## Timing
- Single register stage. fetch_valid in cycle N gives strobes in cycle N+1, each asserted for exactly one cycle.
- fetch_flush or early_flush in cycle N:
  - Instructions accepted in N are discarded.
  - All strobes are 0 in N+1.
  - cnt is 0 in N+1.
- Strobes registered in N (visible in N+1) are not revoked by a flush in N+1, because the RAS restores its own index on the flush.
- ckpt_full is combinational from the registered state. It never depends on fetch_valid.
- Reset values: every output is 0, cnt = 0, ckpt_overflow = 0.
- Reset asserted mid-operation clears state asynchronously, and strobes drop immediately.

## Configuration
- RAS_COROUTINE_EN defined: the rd != rs1 both-link JALR case asserts ras_pop and ras_push in the same cycle. The RAS nets these to a replace-top.
- RAS_COROUTINE_EN undefined: that case asserts only ras_push.
- All other behaviour is identical with and without the macro.

## Structure
- Shared package holds:
  - opcode constants OPC_BRANCH, OPC_JAL, OPC_JALR.
  - ras_op_t enum: RAS_NONE, RAS_PUSH, RAS_POP, RAS_POP_PUSH.
- One combinational sub-module, ras_link_decode: instruction word in, ras_op_t plus is_cf out.
- ras_ctrl itself holds the stage register, the checkpoint counter and the overflow flag.

## Test plan
- JAL x1, pc 0x1000 → next cycle ras_push = 1, ras_new_addr = 0x1004, ras_branch_fetched = 1, cnt = 1.
- JALR x0, 0(x1) → ras_pop = 1, ras_push = 0. Then branch_retired_in → ras_branch_retired = 1, cnt = 0.
- JALR x5, 0(x1), pc 0x2000 → with RAS_COROUTINE_EN: pop = 1, push = 1, addr 0x2004. Without it: push only.
- MAX_IDS = 8; issue 8 BEQs without retire → ckpt_full rises in the cycle the 8th is registered. A 9th BEQ → no strobes, ckpt_overflow = 1.
- 3 branches outstanding, then fetch_flush coincident with a JAL fetch → next cycle no strobes, cnt = 0. A following branch_retired_in produces no ras_branch_retired.
- Simultaneous retire and branch fetch at cnt = 4 → cnt stays 4. Assert rst_n low mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/ras_ctrl_pkg.sv
// Shared opcodes, link-register helpers and RAS operation encoding for ras_ctrl.
package ras_ctrl_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  typedef enum logic [1:0] {
    RAS_NONE     = 2'd0,
    RAS_PUSH     = 2'd1,
    RAS_POP      = 2'd2,
    RAS_POP_PUSH = 2'd3
  } ras_op_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

endpackage

// File: rtl/ras_link_decode.sv
// Combinational call/return classifier for one instruction word.
// RAS_COROUTINE_EN selects pop+push for the rd != rs1 both-link JALR case.
module ras_link_decode
  import ras_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ras_op_t     op,
  output logic        is_cf
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [2:0] funct3;
  logic       rd_link;
  logic       rs1_link;
  logic       unused_bits;

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);
  assign unused_bits = ^instr[31:20];

  always_comb begin
    op    = RAS_NONE;
    is_cf = 1'b0;
    unique case (opcode)
      OPC_BRANCH: is_cf = 1'b1;
      OPC_JAL: begin
        is_cf = 1'b1;
        if (rd_link) op = RAS_PUSH;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          is_cf = 1'b1;
          if (!rd_link && rs1_link) begin
            op = RAS_POP;
          end else if (rd_link && !rs1_link) begin
            op = RAS_PUSH;
          end else if (rd_link && rs1_link) begin
            if (rd == rs1) begin
              op = RAS_PUSH;
            end else begin
`ifdef RAS_COROUTINE_EN
              op = RAS_POP_PUSH;
`else
              op = RAS_PUSH;
`endif
            end
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ras_ctrl.sv
// RAS control: registered push/pop/checkpoint strobes plus checkpoint occupancy tracking.
// Coroutine swap handling is selected in ras_link_decode by RAS_COROUTINE_EN.
module ras_ctrl
  import ras_ctrl_pkg::*;
#(
  parameter int MAX_IDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  input  logic        fetch_flush,
  input  logic        early_flush,
  input  logic        branch_retired_in,
  output logic        ras_push,
  output logic        ras_pop,
  output logic [31:0] ras_new_addr,
  output logic        ras_branch_fetched,
  output logic        ras_branch_retired,
  output logic        ckpt_full,
  output logic        ckpt_overflow
);

  localparam int CW = $clog2(MAX_IDS + 1);

  ras_op_t       op;
  logic          is_cf;
  logic          flush;
  logic          accept;
  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] cnt;
  logic [CW:0]   occupancy;
  logic          push_q;
  logic          pop_q;
  logic          fetched_q;
  logic [31:0]   addr_q;
  logic          overflow_q;

  ras_link_decode u_decode (
    .instr (fetch_instr),
    .op    (op),
    .is_cf (is_cf)
  );

  assign flush   = fetch_flush | early_flush;
  assign accept  = fetch_valid & is_cf & ~ckpt_full & ~flush;
  assign do_push = accept & ((op == RAS_PUSH) | (op == RAS_POP_PUSH));
  assign do_pop  = accept & ((op == RAS_POP)  | (op == RAS_POP_PUSH));

  // The checkpoint still in the register stage counts toward occupancy.
  assign occupancy = {1'b0, cnt} + {{CW{1'b0}}, fetched_q};
  assign ckpt_full = occupancy >= (CW + 1)'(MAX_IDS);

  assign ras_push           = push_q;
  assign ras_pop            = pop_q;
  assign ras_new_addr       = addr_q;
  assign ras_branch_fetched = fetched_q;
  assign ras_branch_retired = branch_retired_in & (cnt != '0);
  assign ckpt_overflow      = overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      fetched_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      push_q    <= do_push;
      pop_q     <= do_pop;
      fetched_q <= accept;
      addr_q    <= do_push ? (fetch_pc + 32'd4) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case ({ras_branch_fetched, ras_branch_retired})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A flushed instruction is discarded, so it cannot be an overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (fetch_valid & is_cf & ckpt_full & ~flush) begin
      overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed self-checking bench for ras_ctrl with hand-computed expectations.
module tb_ras_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic [31:0] fetch_instr = '0;
  logic        fetch_flush = 1'b0;
  logic        early_flush = 1'b0;
  logic        branch_retired_in = 1'b0;
  logic        ras_push;
  logic        ras_pop;
  logic [31:0] ras_new_addr;
  logic        ras_branch_fetched;
  logic        ras_branch_retired;
  logic        ckpt_full;
  logic        ckpt_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ras_ctrl #(.MAX_IDS(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fetch_valid        (fetch_valid),
    .fetch_pc           (fetch_pc),
    .fetch_instr        (fetch_instr),
    .fetch_flush        (fetch_flush),
    .early_flush        (early_flush),
    .branch_retired_in  (branch_retired_in),
    .ras_push           (ras_push),
    .ras_pop            (ras_pop),
    .ras_new_addr       (ras_new_addr),
    .ras_branch_fetched (ras_branch_fetched),
    .ras_branch_retired (ras_branch_retired),
    .ckpt_full          (ckpt_full),
    .ckpt_overflow      (ckpt_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_jal(input logic [4:0] rd);
    return {20'd0, rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [2:0] f3);
    return {12'd0, rs1, f3, rd, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_beq();
    return {7'd0, 5'd2, 5'd3, 3'b000, 5'd0, 7'b1100011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_instr = instr;
    tick();
    fetch_valid = 1'b0;
    fetch_instr = '0;
  endtask

  task automatic chk_strobes(input string tag, input logic push, input logic pop,
                             input logic [31:0] addr, input logic fetched);
    chk({tag, ".push"}, {31'd0, ras_push}, {31'd0, push});
    chk({tag, ".pop"}, {31'd0, ras_pop}, {31'd0, pop});
    chk({tag, ".addr"}, ras_new_addr, addr);
    chk({tag, ".fetched"}, {31'd0, ras_branch_fetched}, {31'd0, fetched});
  endtask

  task automatic clear_cnt();
    fetch_flush = 1'b1;
    tick();
    fetch_flush = 1'b0;
    tick();
  endtask

  initial begin
    logic exp_cor_pop;
`ifdef RAS_COROUTINE_EN
    exp_cor_pop = 1'b1;
`else
    exp_cor_pop = 1'b0;
`endif

    #12;
    chk_strobes("reset", 1'b0, 1'b0, 32'h0, 1'b0);
    chk("reset.full", {31'd0, ckpt_full}, 32'd0);
    chk("reset.ovf", {31'd0, ckpt_overflow}, 32'd0);
    chk("reset.cnt", 32'(dut.cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    fetch(32'h0000_1000, enc_jal(5'd1));
    chk_strobes("jal_x1", 1'b1, 1'b0, 32'h0000_1004, 1'b1);
    tick();
    chk_strobes("jal_x1.one_shot", 1'b0, 1'b0, 32'h0, 1'b0);
    chk("jal_x1.cnt", 32'(dut.cnt), 32'd1);

    fetch(32'h0000_1100, enc_jalr(5'd0, 5'd1, 3'b000));
    chk_strobes("ret", 1'b0, 1'b1, 32'h0, 1'b1);
    tick();
    chk("ret.cnt", 32'(dut.cnt), 32'd2);
    branch_retired_in = 1'b1;
    #1;
    chk("retire1.strobe", {31'd0, ras_branch_retired}, 32'd1);
    tick();
    chk("retire1.cnt", 32'(dut.cnt), 32'd1);
    tick();
    chk("retire2.cnt", 32'(dut.cnt), 32'd0);
    chk("retire_empty.strobe", {31'd0, ras_branch_retired}, 32'd0);
    tick();
    chk("retire_empty.cnt", 32'(dut.cnt), 32'd0);
    branch_retired_in = 1'b0;

    fetch(32'h0000_2000, enc_jalr(5'd5, 5'd1, 3'b000));
    chk_strobes("coroutine", 1'b1, exp_cor_pop, 32'h0000_2004, 1'b1);
    fetch(32'h0000_3000, enc_jalr(5'd1, 5'd1, 3'b000));
    chk_strobes("jalr_x1_x1", 1'b1, 1'b0, 32'h0000_3004, 1'b1);
    fetch(32'h0000_3100, enc_jalr(5'd1, 5'd6, 3'b000));
    chk_strobes("jalr_x1_x6", 1'b1, 1'b0, 32'h0000_3104, 1'b1);
    fetch(32'h0000_3200, enc_jalr(5'd0, 5'd6, 3'b000));
    chk_strobes("jalr_x0_x6", 1'b0, 1'b0, 32'h0, 1'b1);
    fetch(32'h0000_3300, enc_jalr(5'd1, 5'd5, 3'b001));
    chk_strobes("jalr_bad_f3", 1'b0, 1'b0, 32'h0, 1'b0);
    fetch(32'h0000_3400, 32'h0000_0093);
    chk_strobes("addi", 1'b0, 1'b0, 32'h0, 1'b0);
    fetch(32'hFFFF_FFFC, enc_jal(5'd5));
    chk_strobes("jal_wrap", 1'b1, 1'b0, 32'h0, 1'b1);
    fetch(32'h0000_3500, enc_jal(5'd0));
    chk_strobes("jal_x0", 1'b0, 1'b0, 32'h0, 1'b1);
    clear_cnt();
    chk("clear.cnt", 32'(dut.cnt), 32'd0);

    for (int i = 1; i <= 8; i++) begin
      fetch(32'h0000_4000 + 32'(i * 4), enc_beq());
      chk($sformatf("beq%0d.fetched", i), {31'd0, ras_branch_fetched}, 32'd1);
      chk($sformatf("beq%0d.full", i), {31'd0, ckpt_full}, (i == 8) ? 32'd1 : 32'd0);
    end
    fetch(32'h0000_4100, enc_beq());
    chk_strobes("beq9", 1'b0, 1'b0, 32'h0, 1'b0);
    chk("beq9.ovf", {31'd0, ckpt_overflow}, 32'd1);
    chk("beq9.full", {31'd0, ckpt_full}, 32'd1);
    chk("beq9.cnt", 32'(dut.cnt), 32'd8);
    clear_cnt();
    chk("ovf_sticky", {31'd0, ckpt_overflow}, 32'd1);
    chk("flushed.full", {31'd0, ckpt_full}, 32'd0);

    for (int i = 0; i < 3; i++) fetch(32'h0000_5000 + 32'(i * 4), enc_beq());
    tick();
    chk("three.cnt", 32'(dut.cnt), 32'd3);
    fetch_flush = 1'b1;
    fetch(32'h0000_5100, enc_jal(5'd1));
    fetch_flush = 1'b0;
    chk_strobes("flush_jal", 1'b0, 1'b0, 32'h0, 1'b0);
    chk("flush_jal.cnt", 32'(dut.cnt), 32'd0);
    branch_retired_in = 1'b1;
    #1;
    chk("flush_retire.strobe", {31'd0, ras_branch_retired}, 32'd0);
    tick();
    branch_retired_in = 1'b0;

    early_flush = 1'b1;
    fetch(32'h0000_5200, enc_beq());
    early_flush = 1'b0;
    chk_strobes("early_flush", 1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 5; i++) fetch(32'h0000_6000 + 32'(i * 4), enc_beq());
    chk("five.cnt", 32'(dut.cnt), 32'd4);
    branch_retired_in = 1'b1;
    #1;
    chk("simul.retired", {31'd0, ras_branch_retired}, 32'd1);
    tick();
    branch_retired_in = 1'b0;
    chk("simul.cnt", 32'(dut.cnt), 32'd4);

    branch_retired_in = 1'b1;
    fetch(32'h0000_7000, enc_jal(5'd1));
    chk_strobes("pre_rst", 1'b1, 1'b0, 32'h0000_7004, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_strobes("async_rst", 1'b0, 1'b0, 32'h0, 1'b0);
    chk("async_rst.retired", {31'd0, ras_branch_retired}, 32'd0);
    chk("async_rst.full", {31'd0, ckpt_full}, 32'd0);
    chk("async_rst.ovf", {31'd0, ckpt_overflow}, 32'd0);
    chk("async_rst.cnt", 32'(dut.cnt), 32'd0);
    branch_retired_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
